// File: rtl/i2s_rx_frontend.sv
// I2S receiver front end: oversamples bclk/lrck/adcdat with the system clock and
// publishes stereo Q1.15 samples plus a mono pick with a one-cycle new_data strobe.
module i2s_rx_frontend #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MONO_SEL    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              adcdat,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic [DATA_W-1:0] x_out,
    output logic              new_data
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_hist;
    logic                   lrck_hist;
    logic                   bclk_rise_q;
    logic                   lrck_edge_q;
    logic                   lrck_q;
    logic                   bit_q;

    logic                   cur_ch;
    logic                   new_ch;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   active;
    logic                   sw_pending;
    logic [DATA_W-2:0]      shift_reg;
    logic                   commit_q;
    logic                   commit_ch_q;
    logic [DATA_W-1:0]      commit_word_q;

    logic                   cur_ch_n;
    logic                   new_ch_n;
    logic [CNT_W-1:0]       bit_cnt_n;
    logic                   active_n;
    logic                   sw_pending_n;
    logic [DATA_W-2:0]      shift_n;
    logic                   commit_n;
    logic                   commit_ch_n;
    logic [DATA_W-1:0]      commit_word_n;
    logic [DATA_W-1:0]      shifted;
    logic [CNT_W-1:0]       shift_amt;

    logic [DATA_W-1:0]      left_stage;
    logic                   left_valid;
    logic signed [DATA_W:0] avg_sum;
    logic [DATA_W-1:0]      mono;

    // Synchronizers plus one registered edge-detect stage; adcdat travels alongside bclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync   <= '0;
            lrck_sync   <= '0;
            dat_sync    <= '0;
            bclk_hist   <= 1'b0;
            lrck_hist   <= 1'b0;
            bclk_rise_q <= 1'b0;
            lrck_edge_q <= 1'b0;
            lrck_q      <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            bclk_sync   <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrck_sync   <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            dat_sync    <= {dat_sync[SYNC_STAGES-2:0], adcdat};
            bclk_hist   <= bclk_sync[SYNC_STAGES-1];
            lrck_hist   <= lrck_sync[SYNC_STAGES-1];
            bclk_rise_q <= bclk_sync[SYNC_STAGES-1] & ~bclk_hist;
            lrck_edge_q <= lrck_sync[SYNC_STAGES-1] ^ lrck_hist;
            lrck_q      <= lrck_sync[SYNC_STAGES-1];
            bit_q       <= dat_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        cur_ch_n      = cur_ch;
        new_ch_n      = new_ch;
        bit_cnt_n     = bit_cnt;
        active_n      = active;
        sw_pending_n  = sw_pending;
        shift_n       = shift_reg;
        commit_n      = 1'b0;
        commit_ch_n   = cur_ch;
        commit_word_n = '0;
        shifted       = {shift_reg, bit_q};
        shift_amt     = CNT_LAST - bit_cnt;

        if (bclk_rise_q) begin
            if (sw_pending) begin
                // One-bit-delay slot: this bit closes the previous word, left-justified.
                if (active && (bit_cnt < CNT_MAX)) begin
                    commit_n      = 1'b1;
                    commit_word_n = shifted << shift_amt;
                end
                cur_ch_n     = new_ch;
                bit_cnt_n    = '0;
                active_n     = 1'b1;
                sw_pending_n = 1'b0;
            end else if (active && (bit_cnt < CNT_MAX)) begin
                shift_n   = shifted[DATA_W-2:0];
                bit_cnt_n = bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_LAST) begin
                    commit_n      = 1'b1;
                    commit_word_n = shifted;
                end
            end
        end

        if (lrck_edge_q) begin
            sw_pending_n = 1'b1;
            new_ch_n     = lrck_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch        <= 1'b0;
            new_ch        <= 1'b0;
            bit_cnt       <= '0;
            active        <= 1'b0;
            sw_pending    <= 1'b0;
            shift_reg     <= '0;
            commit_q      <= 1'b0;
            commit_ch_q   <= 1'b0;
            commit_word_q <= '0;
        end else begin
            cur_ch        <= cur_ch_n;
            new_ch        <= new_ch_n;
            bit_cnt       <= bit_cnt_n;
            active        <= active_n;
            sw_pending    <= sw_pending_n;
            shift_reg     <= shift_n;
            commit_q      <= commit_n;
            commit_ch_q   <= commit_ch_n;
            commit_word_q <= commit_word_n;
        end
    end

    // Floor average: the extra sign bit keeps the sum exact, so no saturation is needed.
    always_comb begin
        avg_sum = $signed({left_stage[DATA_W-1], left_stage})
                + $signed({commit_word_q[DATA_W-1], commit_word_q});
        if (MONO_SEL == 1) begin
            mono = commit_word_q;
        end else if (MONO_SEL == 2) begin
            mono = DATA_W'(avg_sum >>> 1);
        end else begin
            mono = left_stage;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_stage <= '0;
            left_valid <= 1'b0;
            sample_l   <= '0;
            sample_r   <= '0;
            x_out      <= '0;
            new_data   <= 1'b0;
        end else begin
            new_data <= 1'b0;
            if (commit_q) begin
                if (!commit_ch_q) begin
                    left_stage <= commit_word_q;
                    left_valid <= 1'b1;
                end else if (left_valid) begin
                    sample_l   <= left_stage;
                    sample_r   <= commit_word_q;
                    x_out      <= mono;
                    new_data   <= 1'b1;
                    left_valid <= 1'b0;
                end
            end
        end
    end

endmodule
